// File: rtl/verificador_gray_pkg.sv
// Shared types, default parameters and the Gray-to-binary helper for the
// verificador_gray protocol checker.
package verificador_gray_pkg;

  localparam int DEFAULT_WIDTH      = 5;
  localparam int DEFAULT_LOCK_COUNT = 4;
  localparam int DEFAULT_ERR_W      = 8;

  // Widest word gray2bin handles; narrower words are zero-extended.
  localparam int GRAY_MAX_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t UNLOCKED = 2'd0;
  localparam state_t SYNC     = 2'd1;
  localparam state_t LOCKED   = 2'd2;

  // Leading zeros decode to zeros, so one fixed-width function serves all widths.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/verificador_gray_gray_a_binario.sv
// Combinational Gray-to-binary decoder, WIDTH-parameterised (WIDTH <= 32).
module gray_a_binario
  import verificador_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  assign bin_out = WIDTH'(gray2bin(GRAY_MAX_W'(gray_in)));

endmodule

// File: rtl/verificador_gray.sv
// Gray-sequence checker: decodes accepted samples, locks after LOCK_COUNT good
// increments and counts violations. Define GRAY_ERR_SAT_EN to saturate error_count.
module verificador_gray
  import verificador_gray_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT,
  parameter int ERR_W      = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] entrada_gray,
  output logic [WIDTH-1:0] salida_binaria,
  output logic             valid_out,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] error_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] expected;
  logic             match;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] salida_q, salida_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  gray_a_binario #(.WIDTH(WIDTH)) u_decoder (
    .gray_in (entrada_gray),
    .bin_out (bin)
  );

  // Wrap from all-ones to zero is a legal increment.
  assign expected = last_q + WIDTH'(1);
  assign match    = (bin == expected);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    good_cnt_d = good_cnt_q;
    salida_d   = salida_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (enable) begin
      valid_d  = 1'b1;
      salida_d = bin;
      last_d   = bin;
      case (state_q)
        UNLOCKED: begin
          good_cnt_d = '0;
          state_d    = SYNC;
        end
        SYNC: begin
          if (match) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_q == LOCK_LAST) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            error_d    = 1'b1;
            good_cnt_d = '0;
            state_d    = SYNC;
`ifdef GRAY_ERR_SAT_EN
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
`else
            err_cnt_d = err_cnt_q + ERR_W'(1);
`endif
          end
        end
        default: begin
          good_cnt_d = '0;
          state_d    = UNLOCKED;
        end
      endcase
    end

    // Registered alongside valid_out so it reflects the triggering sample.
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      last_q     <= '0;
      good_cnt_q <= '0;
      salida_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      good_cnt_q <= good_cnt_d;
      salida_q   <= salida_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign salida_binaria = salida_q;
  assign valid_out      = valid_q;
  assign locked         = locked_q;
  assign error          = error_q;
  assign error_count    = err_cnt_q;

endmodule

// File: tb/tb_verificador_gray.sv
// Directed bench for verificador_gray: main instance (ERR_W=8) plus a narrow
// ERR_W=2 instance for the error-counter wrap/saturation behaviour.
module tb_verificador_gray;

  logic       clk;
  logic       reset;
  logic       enable_a;
  logic [4:0] gray_a;
  logic [4:0] bin_a;
  logic       valid_a;
  logic       locked_a;
  logic       error_a;
  logic [7:0] count_a;

  logic       enable_b;
  logic [4:0] gray_b;
  logic [4:0] bin_b;
  logic       valid_b;
  logic       locked_b;
  logic       error_b;
  logic [1:0] count_b;

  int check_count = 0;
  int pass_count  = 0;

  verificador_gray dut_a (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable_a),
    .entrada_gray   (gray_a),
    .salida_binaria (bin_a),
    .valid_out      (valid_a),
    .locked         (locked_a),
    .error          (error_a),
    .error_count    (count_a)
  );

  verificador_gray #(.WIDTH(5), .LOCK_COUNT(4), .ERR_W(2)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable_b),
    .entrada_gray   (gray_b),
    .salida_binaria (bin_b),
    .valid_out      (valid_b),
    .locked         (locked_b),
    .error          (error_b),
    .error_count    (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both instances, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic en_a, input logic [4:0] g_a,
                               input logic en_b, input logic [4:0] g_b);
    enable_a = en_a;
    gray_a   = g_a;
    enable_b = en_b;
    gray_b   = g_b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkState(input string tag, input int b, input int v,
                            input int l, input int e, input int c);
    checkOutput({tag, ".bin"},    32'(bin_a),    32'(b));
    checkOutput({tag, ".valid"},  32'(valid_a),  32'(v));
    checkOutput({tag, ".locked"}, 32'(locked_a), 32'(l));
    checkOutput({tag, ".error"},  32'(error_a),  32'(e));
    checkOutput({tag, ".count"},  32'(count_a),  32'(c));
  endtask

  function automatic logic [4:0] bin2gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int err_pulses;
    int base;
    int exp_cnt;

    reset    = 1'b1;
    enable_a = 1'b0;
    gray_a   = '0;
    enable_b = 1'b0;
    gray_b   = '0;

    applyStimulus(0, 5'b00000, 0, 5'b00000);
    applyStimulus(1, 5'b10101, 0, 5'b00000);
    checkState("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.b_count", 32'(count_b), 0);
    reset = 1'b0;

    // Stream 0..4: lock on the fifth sample.
    applyStimulus(1, 5'b00000, 0, 0); checkState("s1.v0", 0, 1, 0, 0, 0);
    applyStimulus(1, 5'b00001, 0, 0); checkState("s1.v1", 1, 1, 0, 0, 0);
    applyStimulus(1, 5'b00011, 0, 0); checkState("s1.v2", 2, 1, 0, 0, 0);
    applyStimulus(1, 5'b00010, 0, 0); checkState("s1.v3", 3, 1, 0, 0, 0);
    applyStimulus(1, 5'b00110, 0, 0); checkState("s1.v4", 4, 1, 1, 0, 0);

    // Relock at 25..29, then cross the 31 -> 0 wrap while locked.
    reset = 1'b1;
    applyStimulus(0, 5'b00000, 0, 0); checkState("s2.rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 5'b10101, 0, 0); checkState("s2.v25", 25, 1, 0, 0, 0);
    applyStimulus(1, 5'b10111, 0, 0); checkState("s2.v26", 26, 1, 0, 0, 0);
    applyStimulus(1, 5'b10110, 0, 0); checkState("s2.v27", 27, 1, 0, 0, 0);
    applyStimulus(1, 5'b10010, 0, 0); checkState("s2.v28", 28, 1, 0, 0, 0);
    applyStimulus(1, 5'b10011, 0, 0); checkState("s2.v29", 29, 1, 1, 0, 0);
    applyStimulus(1, 5'b10001, 0, 0); checkState("s2.v30", 30, 1, 1, 0, 0);
    applyStimulus(1, 5'b10000, 0, 0); checkState("s2.v31", 31, 1, 1, 0, 0);
    applyStimulus(1, 5'b00000, 0, 0); checkState("s2.v0",   0, 1, 1, 0, 0);
    applyStimulus(1, 5'b00001, 0, 0); checkState("s4.v1",   1, 1, 1, 0, 0);
    applyStimulus(1, 5'b00011, 0, 0); checkState("s4.v2",   2, 1, 1, 0, 0);
    applyStimulus(1, 5'b00010, 0, 0); checkState("s4.v3",   3, 1, 1, 0, 0);
    applyStimulus(1, 5'b00110, 0, 0); checkState("s4.v4",   4, 1, 1, 0, 0);

    // Three idle cycles with junk on the bus: everything must hold.
    applyStimulus(0, 5'b11111, 0, 0); checkState("s4.gap0", 4, 0, 1, 0, 0);
    applyStimulus(0, 5'b01010, 0, 0); checkState("s4.gap1", 4, 0, 1, 0, 0);
    applyStimulus(0, 5'b00110, 0, 0); checkState("s4.gap2", 4, 0, 1, 0, 0);
    applyStimulus(1, 5'b00111, 0, 0); checkState("s4.v5",   5, 1, 1, 0, 0);

    // Skip 6: violation, then relock from 7 after 8,9,10,11.
    applyStimulus(1, 5'b00100, 0, 0); checkState("s3.v7",   7, 1, 0, 1, 1);
    applyStimulus(1, 5'b01100, 0, 0); checkState("s3.v8",   8, 1, 0, 0, 1);
    applyStimulus(1, 5'b01101, 0, 0); checkState("s3.v9",   9, 1, 0, 0, 1);
    applyStimulus(1, 5'b01111, 0, 0); checkState("s3.v10", 10, 1, 0, 0, 1);
    applyStimulus(1, 5'b01110, 0, 0); checkState("s3.v11", 11, 1, 1, 0, 1);
    applyStimulus(1, 5'b01010, 0, 0); checkState("s3.v12", 12, 1, 1, 0, 1);

    // Repeated value is a violation; then relock and violate once more.
    applyStimulus(1, 5'b01010, 0, 0); checkState("rep.v12", 12, 1, 0, 1, 2);
    applyStimulus(1, 5'b01011, 0, 0); checkState("rep.v13", 13, 1, 0, 0, 2);
    applyStimulus(1, 5'b01001, 0, 0); checkState("rep.v14", 14, 1, 0, 0, 2);
    applyStimulus(1, 5'b01000, 0, 0); checkState("rep.v15", 15, 1, 0, 0, 2);
    applyStimulus(1, 5'b11000, 0, 0); checkState("rep.v16", 16, 1, 1, 0, 2);
    applyStimulus(1, 5'b00000, 0, 0); checkState("rep.v0",   0, 1, 0, 1, 3);
    applyStimulus(1, 5'b00001, 0, 0); checkState("rep.v1",   1, 1, 0, 0, 3);
    applyStimulus(1, 5'b00011, 0, 0); checkState("rep.v2",   2, 1, 0, 0, 3);
    applyStimulus(1, 5'b00010, 0, 0); checkState("rep.v3",   3, 1, 0, 0, 3);
    applyStimulus(1, 5'b00110, 0, 0); checkState("rep.v4",   4, 1, 1, 0, 3);

    // Reset beats enable and clears all history, then 0..4 relocks.
    reset = 1'b1;
    applyStimulus(1, 5'b00111, 0, 0); checkState("s5.rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 5'b00000, 0, 0); checkState("s5.v0", 0, 1, 0, 0, 0);
    applyStimulus(1, 5'b00001, 0, 0); checkState("s5.v1", 1, 1, 0, 0, 0);
    applyStimulus(1, 5'b00011, 0, 0); checkState("s5.v2", 2, 1, 0, 0, 0);
    applyStimulus(1, 5'b00010, 0, 0); checkState("s5.v3", 3, 1, 0, 0, 0);
    applyStimulus(1, 5'b00110, 0, 0); checkState("s5.v4", 4, 1, 1, 0, 0);

    // Narrow counter: five lock/violate rounds.
    err_pulses = 0;
    base = 0;
    applyStimulus(0, 0, 1, bin2gray(base));
    checkOutput("s6.start_valid", 32'(valid_b), 1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 1; j <= 4; j++) begin
        base++;
        applyStimulus(0, 0, 1, bin2gray(base));
        checkOutput($sformatf("s6.r%0d.locked%0d", k, j), 32'(locked_b), (j == 4) ? 1 : 0);
      end
      applyStimulus(0, 0, 1, bin2gray(base));
      if (error_b === 1'b1) err_pulses++;
      checkOutput($sformatf("s6.r%0d.error", k), 32'(error_b), 1);
`ifdef GRAY_ERR_SAT_EN
      exp_cnt = (k + 1 > 3) ? 3 : k + 1;
`else
      exp_cnt = (k + 1) % 4;
`endif
      checkOutput($sformatf("s6.r%0d.count", k), 32'(count_b), 32'(exp_cnt));
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("s6.error_idle", 32'(error_b), 0);
    checkOutput("s6.pulses", 32'(err_pulses), 5);
`ifdef GRAY_ERR_SAT_EN
    checkOutput("s6.final_count", 32'(count_b), 3);
`else
    checkOutput("s6.final_count", 32'(count_b), 1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
